// File: rtl/scaler_pkg.sv
// scaler_pkg: default geometry constants and window-index helper for the
// scaler_gen block.
//   STAGES_DEF  - default number of binary scaler stages
//   CHAN_W_DEF  - default readout word width
//   CHB_LSB_DEF - default stage index of CHBT bit 0
//   chat_lsb()  - stage index of CHAT bit 0 (upper window directly above CHBT)
package scaler_pkg;

    localparam int unsigned STAGES_DEF  = 33;
    localparam int unsigned CHAN_W_DEF  = 14;
    localparam int unsigned CHB_LSB_DEF = 5;

    function automatic int unsigned chat_lsb(input int unsigned chb_lsb,
                                             input int unsigned chan_w);
        return chb_lsb + chan_w;
    endfunction

endpackage

// File: rtl/scaler_readout.sv
// scaler_readout: registered channel readout of the scaler count, with an
// optional coherent-readout snapshot of the upper window.
// Build option: define SCALER_SNAPSHOT_EN to enable the snapshot register.
//   clk, rst_n - clock, asynchronous active-low reset
//   lo_win     - pre-update count bits feeding CHBT
//   hi_win     - pre-update count bits feeding CHAT
//   rchat_n    - active-low upper-channel read strobe
//   rchbt_n    - active-low lower-channel read strobe
//   chat, chbt - registered readout words (zero when not strobed)
module scaler_readout
    import scaler_pkg::*;
#(
    parameter int unsigned CHAN_W = CHAN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAN_W-1:0] lo_win,
    input  logic [CHAN_W-1:0] hi_win,
    input  logic              rchat_n,
    input  logic              rchbt_n,
    output logic [CHAN_W-1:0] chat,
    output logic [CHAN_W-1:0] chbt
);

`ifdef SCALER_SNAPSHOT_EN
    logic [CHAN_W-1:0] snap;
    logic              snap_valid;

    // Lower-only read freezes the upper window so a following upper read
    // pairs coherently with it; any upper read consumes the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chat       <= '0;
            chbt       <= '0;
            snap       <= '0;
            snap_valid <= 1'b0;
        end else begin
            chbt <= rchbt_n ? '0 : lo_win;
            if (!rchat_n) begin
                chat       <= (snap_valid && rchbt_n) ? snap : hi_win;
                snap_valid <= 1'b0;
            end else begin
                chat <= '0;
                if (!rchbt_n) begin
                    snap       <= hi_win;
                    snap_valid <= 1'b1;
                end
            end
        end
    end
`else
    // Live readout of both windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chat <= '0;
            chbt <= '0;
        end else begin
            chbt <= rchbt_n ? '0 : lo_win;
            chat <= rchat_n ? '0 : hi_win;
        end
    end
`endif

endmodule

// File: rtl/scaler_gen.sv
// scaler_gen: STAGES-bit binary scaler with per-stage rising/falling edge
// pulses, wrap pulse, preset load and two-channel registered readout.
// Build option: define SCALER_SNAPSHOT_EN for coherent CHAT/CHBT readout.
//   SIM_CLK, GOJAM_ - clock, asynchronous active-low reset
//   ADV, HOLD       - advance pulse, advance inhibit
//   PRESET, PRESET_D- load count (priority over ADV, no edge pulses)
//   RCHAT_, RCHBT_  - active-low channel read strobes
//   FS              - count; FA/FB per-stage 0->1 / 1->0 pulses
//   CHAT, CHBT      - readout words; OVFL - wrap pulse
module scaler_gen
    import scaler_pkg::*;
#(
    parameter int unsigned STAGES  = STAGES_DEF,
    parameter int unsigned CHAN_W  = CHAN_W_DEF,
    parameter int unsigned CHB_LSB = CHB_LSB_DEF
) (
    input  logic              SIM_CLK,
    input  logic              GOJAM_,
    input  logic              ADV,
    input  logic              HOLD,
    input  logic              PRESET,
    input  logic [STAGES-1:0] PRESET_D,
    input  logic              RCHAT_,
    input  logic              RCHBT_,
    output logic [STAGES-1:0] FS,
    output logic [STAGES-1:0] FA,
    output logic [STAGES-1:0] FB,
    output logic [CHAN_W-1:0] CHAT,
    output logic [CHAN_W-1:0] CHBT,
    output logic              OVFL
);

    localparam int unsigned CHAT_LSB = chat_lsb(CHB_LSB, CHAN_W);

    logic [STAGES-1:0] fs_q;
    logic [STAGES-1:0] fs_inc;

    assign fs_inc = fs_q + STAGES'(1);

    // Count, edge pulses and wrap pulse; PRESET wins and is pulse-silent.
    always_ff @(posedge SIM_CLK or negedge GOJAM_) begin
        if (!GOJAM_) begin
            fs_q <= '0;
            FA   <= '0;
            FB   <= '0;
            OVFL <= 1'b0;
        end else if (PRESET) begin
            fs_q <= PRESET_D;
            FA   <= '0;
            FB   <= '0;
            OVFL <= 1'b0;
        end else if (ADV && !HOLD) begin
            fs_q <= fs_inc;
            FA   <= fs_inc & ~fs_q;
            FB   <= fs_q & ~fs_inc;
            OVFL <= &fs_q;
        end else begin
            FA   <= '0;
            FB   <= '0;
            OVFL <= 1'b0;
        end
    end

    assign FS = fs_q;

    // Readout sees the count before this edge's update.
    scaler_readout #(
        .CHAN_W (CHAN_W)
    ) u_readout (
        .clk     (SIM_CLK),
        .rst_n   (GOJAM_),
        .lo_win  (fs_q[CHB_LSB +: CHAN_W]),
        .hi_win  (fs_q[CHAT_LSB +: CHAN_W]),
        .rchat_n (RCHAT_),
        .rchbt_n (RCHBT_),
        .chat    (CHAT),
        .chbt    (CHBT)
    );

endmodule
